spi_cmd_sequencer: RTL and testbench

Upstream command source for the SPI master. Holds a host-loaded table of SPI transactions and, on `start`, replays entries `0..seq_len-1` as 32-bit words into the master's command FIFO write port, honouring FIFO `full`. Used for ADC/DAC power-up and configuration sequences without per-word host writes. Shares `clk` with the FIFO's `wr_clk` side.

---
 rtl/spi_seq_pkg.sv | 25 ++
 rtl/spi_seq_tbl.sv | 25 ++
 rtl/spi_cmd_sequencer.sv | 121 ++++++++++++
 tb/tb_spi_cmd_sequencer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_seq_pkg.sv
// Shared definitions for the SPI command sequencer: table entry layout,
// FIFO word header format and the sequencer state encoding.
package spi_seq_pkg;

  localparam int ENTRY_W  = 26;
  localparam int CPHA_B   = 25;
  localparam int CPOL_B   = 24;
  localparam int SS_LSB   = 16;
  localparam int DATA_LSB = 0;

  localparam logic [5:0] HDR_PAD = 6'b000000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_WRITE,
    S_GAP
  } state_t;

  // Data goes in the upper half because the FIFO presents that half first.
  function automatic logic [31:0] fmt_word(input logic [ENTRY_W-1:0] e);
    return {e[DATA_LSB +: 16], HDR_PAD, e[CPHA_B], e[CPOL_B], e[SS_LSB +: 8]};
  endfunction

endpackage

// File: rtl/spi_seq_tbl.sv
// Transaction table: simple dual-port RAM, host write port and a registered
// read port. No reset so it can map onto block or distributed RAM.
module spi_seq_tbl
  import spi_seq_pkg::*;
#(
  parameter int AW = 6
) (
  input  logic               i_clk,
  input  logic               i_wr_en,
  input  logic [AW-1:0]      i_wr_addr,
  input  logic [ENTRY_W-1:0] i_wr_data,
  input  logic [AW-1:0]      i_rd_addr,
  output logic [ENTRY_W-1:0] o_rd_data
);

  logic [ENTRY_W-1:0] r_mem [2**AW];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    o_rd_data <= r_mem[i_rd_addr];
  end

endmodule

// File: rtl/spi_cmd_sequencer.sv
// Replays a host-loaded table of SPI transactions into the SPI master's
// command FIFO, honouring FIFO full, with optional inter-write gap and looping.
//
// state   | meaning
// S_IDLE  | waiting for start
// S_FETCH | table address presented, read data valid next cycle
// S_WRITE | push formatted word unless FIFO full
// S_GAP   | idle spacing after a write, end-of-pass decision
module spi_cmd_sequencer
  import spi_seq_pkg::*;
#(
  parameter int AW         = 6,
  parameter int GAP_CYCLES = 0
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_tbl_wr_en,
  input  logic [AW-1:0]      i_tbl_addr,
  input  logic [ENTRY_W-1:0] i_tbl_data,
  input  logic [AW:0]        i_seq_len,
  input  logic               i_start,
  input  logic               i_abort,
  input  logic               i_loop,
  input  logic               i_fifo_full,
  output logic               o_fifo_wr_en,
  output logic [31:0]        o_fifo_wr_data,
  output logic               o_busy,
  output logic               o_done,
  output logic [AW-1:0]      o_cur_idx
);

  localparam logic [15:0] GAP_LOAD = (GAP_CYCLES > 0) ? 16'(GAP_CYCLES - 1) : 16'd0;

  state_t             r_state;
  logic [AW:0]        r_len;
  logic [AW-1:0]      r_idx;
  logic [15:0]        r_gap_cnt;
  logic [ENTRY_W-1:0] w_rd_data;
  logic               w_last;
  logic               w_tbl_we;

  assign w_last    = ({1'b0, r_idx} == (r_len - 1'b1));
  assign w_tbl_we  = i_tbl_wr_en & ~o_busy;
  assign o_cur_idx = r_idx;

  spi_seq_tbl #(.AW(AW)) u_tbl (
    .i_clk     (i_clk),
    .i_wr_en   (w_tbl_we),
    .i_wr_addr (i_tbl_addr),
    .i_wr_data (i_tbl_data),
    .i_rd_addr (r_idx),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= S_IDLE;
      r_len          <= '0;
      r_idx          <= '0;
      r_gap_cnt      <= '0;
      o_fifo_wr_en   <= 1'b0;
      o_fifo_wr_data <= '0;
      o_busy         <= 1'b0;
      o_done         <= 1'b0;
    end else begin
      o_fifo_wr_en <= 1'b0;
      o_done       <= 1'b0;
      if (i_abort) begin
        r_state <= S_IDLE;
        o_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (i_start) begin
              if (i_seq_len != '0) begin
                r_len   <= i_seq_len;
                r_idx   <= '0;
                r_state <= S_FETCH;
                o_busy  <= 1'b1;
              end else begin
                o_done <= 1'b1;
              end
            end
          end
          S_FETCH: r_state <= S_WRITE;
          S_WRITE: begin
            if (!i_fifo_full) begin
              o_fifo_wr_en   <= 1'b1;
              o_fifo_wr_data <= fmt_word(w_rd_data);
              // A finishing pass always takes one GAP cycle so done trails the last write.
              if ((GAP_CYCLES > 0) || (w_last && !i_loop)) begin
                r_gap_cnt <= GAP_LOAD;
                r_state   <= S_GAP;
              end else begin
                r_idx   <= w_last ? '0 : r_idx + 1'b1;
                r_state <= S_FETCH;
              end
            end
          end
          S_GAP: begin
            if (r_gap_cnt != '0) begin
              r_gap_cnt <= r_gap_cnt - 1'b1;
            end else if (!w_last) begin
              r_idx   <= r_idx + 1'b1;
              r_state <= S_FETCH;
            end else if (i_loop) begin
              r_idx   <= '0;
              r_state <= S_FETCH;
            end else begin
              r_state <= S_IDLE;
              o_busy  <= 1'b0;
              o_done  <= 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Self-checking bench: two instances (GAP 0 and GAP 4) share stimulus and are
// checked cycle by cycle against a timing/word model plus fixed vectors.
module tb_spi_cmd_sequencer;

  localparam int AW = 6;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tbl_wr_en;
  logic [5:0]  tbl_addr;
  logic [25:0] tbl_data;
  logic [6:0]  seq_len;
  logic        start, abort, loop, fifo_full;

  logic [1:0]  wr_en, done, busy;
  logic [31:0] wd  [2];
  logic [5:0]  idx [2];

  int checks   = 0;
  int failures = 0;
  int e        = 0;

  typedef struct {
    logic [25:0] entry;
    logic [31:0] word;
  } vec_t;
  vec_t vecs [6];

  logic [25:0] tbl_m [64];
  logic [31:0] cap0 [$];

  always #5 clk = ~clk;
  always @(posedge clk) e <= e + 1;

  spi_cmd_sequencer #(.AW(AW), .GAP_CYCLES(0)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_tbl_wr_en(tbl_wr_en), .i_tbl_addr(tbl_addr),
    .i_tbl_data(tbl_data), .i_seq_len(seq_len), .i_start(start), .i_abort(abort),
    .i_loop(loop), .i_fifo_full(fifo_full), .o_fifo_wr_en(wr_en[0]),
    .o_fifo_wr_data(wd[0]), .o_busy(busy[0]), .o_done(done[0]), .o_cur_idx(idx[0])
  );

  spi_cmd_sequencer #(.AW(AW), .GAP_CYCLES(4)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_tbl_wr_en(tbl_wr_en), .i_tbl_addr(tbl_addr),
    .i_tbl_data(tbl_data), .i_seq_len(seq_len), .i_start(start), .i_abort(abort),
    .i_loop(loop), .i_fifo_full(fifo_full), .o_fifo_wr_en(wr_en[1]),
    .o_fifo_wr_data(wd[1]), .o_busy(busy[1]), .o_done(done[1]), .o_cur_idx(idx[1])
  );

  function automatic logic [31:0] mk_word(input logic [25:0] en);
    return {en[15:0], 6'b000000, en[25], en[24], en[23:16]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int a, input logic [25:0] d);
    tbl_wr_en = 1'b1;
    tbl_addr  = 6'(a);
    tbl_data  = d;
    tick();
    tbl_wr_en = 1'b0;
    tbl_m[a]  = d;
  endtask

  // Expected behaviour: first write sampled 2 edges after the start edge, each
  // later write 2+gap edges after the previous, slipping one edge per full
  // cycle; done lands max(gap,1) edges after the last write.
  task automatic play(input string tag, input int len, input int full_pct,
                      input int full_at, input int full_n, input int junk_at);
    int   due [2];
    int   widx [2];
    int   dedge [2];
    int   gap [2];
    int   e0, nxt;
    logic cur_full, exp_we;
    bit   fin;
    gap[0] = 0;
    gap[1] = 4;
    fin    = 1'b0;
    cap0.delete();
    seq_len = 7'(len);
    start   = 1'b1;
    tick();
    start = 1'b0;
    e0    = e;
    for (int d = 0; d < 2; d++) begin
      due[d]   = e0 + 2;
      widx[d]  = 0;
      dedge[d] = -1;
      chk($sformatf("%s_busy_rise%0d", tag, d), busy[d], 1'b1);
    end
    for (int n = 0; n < 3000 && !fin; n++) begin
      nxt       = e + 1 - e0;
      fifo_full = (nxt >= full_at && nxt < full_at + full_n) ||
                  (full_pct > 0 && int'($urandom_range(0, 99)) < full_pct);
      if (nxt == junk_at) begin
        start     = 1'b1;
        seq_len   = 7'd1;
        tbl_wr_en = 1'b1;
        tbl_addr  = 6'd0;
        tbl_data  = 26'h2ABCDEF;
      end
      cur_full = fifo_full;
      tick();
      start     = 1'b0;
      tbl_wr_en = 1'b0;
      for (int d = 0; d < 2; d++) begin
        exp_we = (e == due[d]) && !cur_full;
        chk($sformatf("%s_we%0d_e%0d", tag, d, e - e0), wr_en[d], exp_we);
        if (exp_we) begin
          chk($sformatf("%s_word%0d_i%0d", tag, d, widx[d]), wd[d], mk_word(tbl_m[widx[d]]));
          if (d == 0) cap0.push_back(wd[0]);
        end
        chk($sformatf("%s_done%0d_e%0d", tag, d, e - e0), done[d], e == dedge[d]);
        chk($sformatf("%s_busy%0d_e%0d", tag, d, e - e0), busy[d], (dedge[d] < 0) || (e < dedge[d]));
        if (e == due[d]) begin
          if (cur_full) begin
            due[d] = e + 1;
          end else begin
            widx[d]++;
            if (widx[d] == len) begin
              dedge[d] = e + ((gap[d] > 0) ? gap[d] : 1);
              due[d]   = -1;
            end else begin
              due[d] = e + 2 + gap[d];
            end
          end
        end
      end
      fin = (dedge[0] >= 0) && (dedge[1] >= 0) && (e > dedge[0]) && (e > dedge[1]);
    end
    fifo_full = 1'b0;
    if (!fin) chk({tag, "_timeout"}, 0, 1);
  endtask

  initial begin
    int          nw;
    logic        sawx;
    rst_n     = 1'b0;
    tbl_wr_en = 1'b0;
    tbl_addr  = '0;
    tbl_data  = '0;
    seq_len   = '0;
    start     = 1'b0;
    abort     = 1'b0;
    loop      = 1'b0;
    fifo_full = 1'b0;

    vecs[0] = '{{2'b00, 8'h01, 16'hA5A5}, 32'hA5A5_0001};
    vecs[1] = '{{2'b10, 8'h02, 16'h1234}, 32'h1234_0202};
    vecs[2] = '{{2'b01, 8'h80, 16'hFFFF}, 32'hFFFF_0180};
    vecs[3] = '{{2'b11, 8'hFF, 16'hFFFF}, 32'hFFFF_03FF};
    vecs[4] = '{26'd0, 32'h0000_0000};
    vecs[5] = '{{2'b10, 8'h00, 16'h0001}, 32'h0001_0200};

    repeat (3) tick();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_we%0d", d), wr_en[d], 1'b0);
      chk($sformatf("rst_data%0d", d), wd[d], 32'h0);
      chk($sformatf("rst_busy%0d", d), busy[d], 1'b0);
      chk($sformatf("rst_done%0d", d), done[d], 1'b0);
      chk($sformatf("rst_idx%0d", d), idx[d], 6'd0);
    end
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) load(i, vecs[i].entry);

    play("basic", 3, 0, -1, 0, -1);
    play("full", 3, 0, 4, 10, -1);

    play("vec", 6, 0, -1, 0, -1);
    chk("vec_count", cap0.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < cap0.size()) chk($sformatf("vec_fmt%0d", i), cap0[i], vecs[i].word);
    end

    seq_len = 7'd0;
    start   = 1'b1;
    tick();
    start = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("len0_done%0d", d), done[d], 1'b1);
      chk($sformatf("len0_busy%0d", d), busy[d], 1'b0);
      chk($sformatf("len0_we%0d", d), wr_en[d], 1'b0);
    end
    tick();
    chk("len0_done_clr", done, 2'b00);

    seq_len = 7'd2;
    start   = 1'b1;
    abort   = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    sawx  = 1'b0;
    for (int n = 0; n < 5; n++) begin
      sawx |= (|wr_en) | (|busy) | (|done);
      tick();
    end
    chk("start_abort_idle", sawx, 1'b0);

    seq_len = 7'd2;
    loop    = 1'b1;
    start   = 1'b1;
    tick();
    start = 1'b0;
    nw    = 0;
    sawx  = 1'b0;
    for (int n = 0; n < 100 && nw < 5; n++) begin
      tick();
      sawx |= (|done);
      if (wr_en[0]) begin
        chk($sformatf("loop_word%0d", nw), wd[0], mk_word(tbl_m[nw % 2]));
        nw++;
      end
    end
    chk("loop_count", nw, 5);
    chk("loop_no_done", sawx, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    loop  = 1'b0;
    chk("abort_busy", busy, 2'b00);
    chk("abort_we", wr_en, 2'b00);
    sawx = 1'b0;
    for (int n = 0; n < 6; n++) begin
      sawx |= (|wr_en) | (|done) | (|busy);
      tick();
    end
    chk("abort_quiet", sawx, 1'b0);

    seq_len = 7'd3;
    start   = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("async_we", wr_en, 2'b00);
    chk("async_busy", busy, 2'b00);
    chk("async_data0", wd[0], 32'h0);
    chk("async_idx0", idx[0], 6'd0);
    tick();
    rst_n = 1'b1;
    tick();
    play("after_rst", 3, 0, -1, 0, 3);
    play("after_junk", 3, 0, -1, 0, -1);

    for (int it = 0; it < 8; it++) begin
      int len;
      len = (it == 7) ? 64 : int'($urandom_range(1, 8));
      for (int i = 0; i < len; i++) load(i, 26'($urandom));
      play($sformatf("rnd%0d", it), len, int'($urandom_range(0, 40)), -1, 0, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
